// File: rtl/fa_bist_pkg.sv
// Shared types and constants for the full-adder BIST response analyser.
package fa_bist_pkg;

  localparam int unsigned VEC_W    = 3;
  localparam int unsigned FA_CODES = 8;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } state_e;

endpackage

// File: rtl/fa_golden_model.sv
// Reference 1-bit full adder used to judge the responses of the cell under test.
module fa_golden_model (
  input  logic a_i,
  input  logic b_i,
  input  logic c_in_i,
  output logic g_sum_o,
  output logic g_cout_o
);

  always_comb begin
    g_sum_o  = a_i ^ b_i ^ c_in_i;
    g_cout_o = (a_i & b_i) | (c_in_i & (a_i ^ b_i));
  end

endmodule

// File: rtl/fa_bist_checker.sv
// Response analyser: compares each applied {a,b,c_in} vector's DUT outputs against a golden
// full adder, accumulating error count, first failing vector and code coverage per run.
module fa_bist_checker
  import fa_bist_pkg::*;
#(
  parameter int unsigned N_VECTORS = 8,
  parameter int unsigned CNT_W     = 16,
  parameter int unsigned ERR_W     = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                vec_valid,
  input  logic [VEC_W-1:0]    vec,
  input  logic                dut_cout,
  input  logic                dut_sum,
  output logic                busy,
  output logic                done,
  output logic                pass,
  output logic                err_pulse,
  output logic [ERR_W-1:0]    err_count,
  output logic [VEC_W-1:0]    first_err_vec,
  output logic                first_err_seen,
  output logic [FA_CODES-1:0] coverage
);

  localparam logic [CNT_W-1:0] NVec   = CNT_W'(N_VECTORS);
  localparam logic [ERR_W-1:0] ErrMax = '1;

  logic g_sum;
  logic g_cout;

  fa_golden_model u_golden (
    .a_i      (vec[2]),
    .b_i      (vec[1]),
    .c_in_i   (vec[0]),
    .g_sum_o  (g_sum),
    .g_cout_o (g_cout)
  );

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [ERR_W-1:0]    err_cnt_q, err_cnt_d;
  logic [VEC_W-1:0]    first_err_vec_q, first_err_vec_d;
  logic                first_err_seen_q, first_err_seen_d;
  logic [FA_CODES-1:0] cov_q, cov_d;
  logic                err_pulse_q, err_pulse_d;
  logic                pass_q, pass_d;
  logic                mismatch;

  assign mismatch = (dut_sum != g_sum) | (dut_cout != g_cout);

  always_comb begin
    state_d          = state_q;
    cnt_d            = cnt_q;
    err_cnt_d        = err_cnt_q;
    first_err_vec_d  = first_err_vec_q;
    first_err_seen_d = first_err_seen_q;
    cov_d            = cov_q;
    err_pulse_d      = 1'b0;
    pass_d           = pass_q;

    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          state_d          = StRun;
          cnt_d            = '0;
          err_cnt_d        = '0;
          first_err_vec_d  = '0;
          first_err_seen_d = 1'b0;
          cov_d            = '0;
          pass_d           = 1'b0;
        end
      end
      StRun: begin
        // start is deliberately not looked at here: a run cannot be restarted while busy.
        if (vec_valid) begin
          cnt_d      = cnt_q + 1'b1;
          cov_d[vec] = 1'b1;
          if (mismatch) begin
            err_pulse_d = 1'b1;
            if (err_cnt_q != ErrMax) begin
              err_cnt_d = err_cnt_q + 1'b1;
            end
            if (!first_err_seen_q) begin
              first_err_vec_d  = vec;
              first_err_seen_d = 1'b1;
            end
          end
          // Verdict uses the counts including this final vector.
          if (cnt_d == NVec) begin
            state_d = StDone;
            pass_d  = (err_cnt_d == '0) & (&cov_d);
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q          <= StIdle;
      cnt_q            <= '0;
      err_cnt_q        <= '0;
      first_err_vec_q  <= '0;
      first_err_seen_q <= 1'b0;
      cov_q            <= '0;
      err_pulse_q      <= 1'b0;
      pass_q           <= 1'b0;
    end else begin
      state_q          <= state_d;
      cnt_q            <= cnt_d;
      err_cnt_q        <= err_cnt_d;
      first_err_vec_q  <= first_err_vec_d;
      first_err_seen_q <= first_err_seen_d;
      cov_q            <= cov_d;
      err_pulse_q      <= err_pulse_d;
      pass_q           <= pass_d;
    end
  end

  always_comb begin
    busy           = (state_q == StRun);
    done           = (state_q == StDone);
    pass           = pass_q;
    err_pulse      = err_pulse_q;
    err_count      = err_cnt_q;
    first_err_vec  = first_err_vec_q;
    first_err_seen = first_err_seen_q;
    coverage       = cov_q;
  end

endmodule
